reg_writeback_unit: RTL

//  Parametrised, registered writeback stage of the Simple Processor. Successor to the 2-way register-write select.

---
 rtl/reg_writeback_unit_pkg.sv | 21 ++
 rtl/reg_writeback_unit_load_extend.sv | 49 ++++
 rtl/reg_writeback_unit.sv | 134 +++++++++++++
 3 files changed

// File: rtl/reg_writeback_unit_pkg.sv
// cpu_wb_pkg: shared encodings for the writeback stage.
//   WRITESEL codes  : WB_ALU, WB_MEM, WB_ALT (3 is reserved and behaves as WB_ALU)
//   LOADMODE codes  : LM_WORD, LM_BYTE_S, LM_BYTE_U, LM_HALF_S
//   FSM state type  : wb_state_t with S_IDLE / S_WAIT_MEM
package cpu_wb_pkg;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_ALT = 2'd2;

    localparam logic [1:0] LM_WORD   = 2'd0;
    localparam logic [1:0] LM_BYTE_S = 2'd1;
    localparam logic [1:0] LM_BYTE_U = 2'd2;
    localparam logic [1:0] LM_HALF_S = 2'd3;

    typedef enum logic {
        S_IDLE     = 1'b0,
        S_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage

// File: rtl/reg_writeback_unit_load_extend.sv
// load_extend: combinational sub-word load extension.
//   d    in  DATA_W  raw data-memory read data
//   mode in  2       LM_WORD / LM_BYTE_S / LM_BYTE_U / LM_HALF_S
//   q    out DATA_W  extended value
// DATA_W is expected to be 8, 16 or 32. At 8 bits every mode is a
// pass-through; at 16 bits the half-word mode is a pass-through.
module load_extend
    import cpu_wb_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] byte_s;
    logic [DATA_W-1:0] byte_u;
    logic [DATA_W-1:0] half_s;

    // Widths where an extension would need a zero-length replication are
    // handled as plain pass-throughs.
    generate
        if (DATA_W == 8) begin : g_w8
            assign byte_s = d;
            assign byte_u = d;
            assign half_s = d;
        end else if (DATA_W == 16) begin : g_w16
            assign byte_s = {{8{d[7]}}, d[7:0]};
            assign byte_u = {8'h00, d[7:0]};
            assign half_s = d;
        end else begin : g_wide
            assign byte_s = {{(DATA_W-8){d[7]}}, d[7:0]};
            assign byte_u = {{(DATA_W-8){1'b0}}, d[7:0]};
            assign half_s = {{(DATA_W-16){d[15]}}, d[15:0]};
        end
    endgenerate

    always_comb begin
        q = d;
        case (mode)
            LM_BYTE_S: q = byte_s;
            LM_BYTE_U: q = byte_u;
            LM_HALF_S: q = half_s;
            default:   q = d;
        endcase
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// reg_writeback_unit: registered writeback stage between the ALU / data
// memory and the register file.
//   CLK, RESET          clock (rising edge), asynchronous active-high reset
//   VALID_IN            writeback request present
//   WRITEENABLE_IN      request writes the register file
//   WRITEADDR_IN        destination register
//   WRITESEL            source: ALU result / memory read data / alternate
//   LOADMODE            load extension mode for memory data
//   RESULT, READDATA, ALTDATA  candidate write data
//   BUSYWAIT            data memory not ready
//   IN, WRITEADDR, WRITEENABLE  registered register-file write port
//   STALL               upstream must hold its inputs this cycle
//   STALL_CNT           saturating count of stalled cycles
//   DBG_STATE           current FSM state (1 = waiting for memory)
//
// Handshake: a request is taken on a rising edge where VALID_IN=1 and
// STALL=0. While STALL=1 the upstream keeps every input stable; in the
// memory-wait state only READDATA and BUSYWAIT are looked at, and the
// destination, enable and load mode come from the copies latched at accept.
module reg_writeback_unit
    import cpu_wb_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int REG_ADDR_W = 3,
    parameter int ZERO_REG   = 0,
    parameter int CNT_W      = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VALID_IN,
    input  logic                  WRITEENABLE_IN,
    input  logic [REG_ADDR_W-1:0] WRITEADDR_IN,
    input  logic [1:0]            WRITESEL,
    input  logic [1:0]            LOADMODE,
    input  logic [DATA_W-1:0]     RESULT,
    input  logic [DATA_W-1:0]     READDATA,
    input  logic [DATA_W-1:0]     ALTDATA,
    input  logic                  BUSYWAIT,
    output logic [DATA_W-1:0]     IN,
    output logic [REG_ADDR_W-1:0] WRITEADDR,
    output logic                  WRITEENABLE,
    output logic                  STALL,
    output logic [CNT_W-1:0]      STALL_CNT,
    output logic                  DBG_STATE
);

    localparam logic             ZERO_EN = (ZERO_REG != 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    wb_state_t             state;
    logic [REG_ADDR_W-1:0] lat_addr;
    logic                  lat_we;
    logic [1:0]            lat_mode;

    logic [1:0]            ext_mode;
    logic [DATA_W-1:0]     ext_data;
    logic [DATA_W-1:0]     sel_data;
    logic                  idle_load;
    logic                  we_new;
    logic                  we_lat;

    // While waiting, the extension must use the mode captured at accept,
    // since upstream inputs are no longer meaningful.
    assign ext_mode = (state == S_WAIT_MEM) ? lat_mode : LOADMODE;

    load_extend #(.DATA_W(DATA_W)) u_load_extend (
        .d    (READDATA),
        .mode (ext_mode),
        .q    (ext_data)
    );

    always_comb begin
        sel_data = RESULT;
        case (WRITESEL)
            WB_MEM:  sel_data = ext_data;
            WB_ALT:  sel_data = ALTDATA;
            default: sel_data = RESULT;
        endcase
    end

    assign idle_load = (state == S_IDLE) && VALID_IN && (WRITESEL == WB_MEM);
    assign STALL     = (idle_load && BUSYWAIT) || (state == S_WAIT_MEM);
    assign DBG_STATE = (state == S_WAIT_MEM);

    // A hard-wired register 0 never sees a write strobe.
    assign we_new = WRITEENABLE_IN && !(ZERO_EN && (WRITEADDR_IN == '0));
    assign we_lat = lat_we && !(ZERO_EN && (lat_addr == '0));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state       <= S_IDLE;
            IN          <= '0;
            WRITEADDR   <= '0;
            WRITEENABLE <= 1'b0;
            lat_addr    <= '0;
            lat_we      <= 1'b0;
            lat_mode    <= LM_WORD;
        end else begin
            WRITEENABLE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (VALID_IN && !STALL) begin
                        IN          <= sel_data;
                        WRITEADDR   <= WRITEADDR_IN;
                        WRITEENABLE <= we_new;
                    end else if (idle_load && BUSYWAIT) begin
                        lat_addr <= WRITEADDR_IN;
                        lat_we   <= WRITEENABLE_IN;
                        lat_mode <= LOADMODE;
                        state    <= S_WAIT_MEM;
                    end
                end
                S_WAIT_MEM: begin
                    if (!BUSYWAIT) begin
                        IN          <= ext_data;
                        WRITEADDR   <= lat_addr;
                        WRITEENABLE <= we_lat;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            STALL_CNT <= '0;
        end else if (STALL && (STALL_CNT != CNT_MAX)) begin
            STALL_CNT <= STALL_CNT + CNT_W'(1);
        end
    end

endmodule
